// File: rtl/bht_update_ctrl.sv
// Write sequencer for the branch history table RAM: clear sweep after reset/flush and
// read-modify-write of 2-bit saturating counters for resolved branches queued in a small FIFO.
module bht_update_ctrl #(
  parameter int unsigned VLEN           = 64,
  parameter int unsigned BHT_OFFSET     = 1,
  parameter int unsigned BHT_ROW_BITS   = 1,
  parameter int unsigned BHT_LOG_ROWS   = 6,
  parameter int unsigned UPD_FIFO_DEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_bp_i,
  input  logic                    upd_valid_i,
  output logic                    upd_ready_o,
  input  logic [VLEN-1:0]         upd_pc_i,
  input  logic                    upd_taken_i,
  output logic                    bht_busy_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [BHT_LOG_ROWS-1:0] mem_addr_o,
  output logic [1:0]              mem_be_o,
  output logic [5:0]              mem_wdata_o,
  input  logic [5:0]              mem_rdata_i
);

  localparam int unsigned PtrW = (UPD_FIFO_DEPTH > 1) ? $clog2(UPD_FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(UPD_FIFO_DEPTH);
  localparam logic [BHT_LOG_ROWS-1:0] LastRow = '1;

  typedef enum logic [1:0] {StSweep, StIdle, StRd, StWr} state_e;

  state_e                  state_q, state_d;
  logic [BHT_LOG_ROWS-1:0] sweep_idx_q, sweep_idx_d;

  // Pending-update queue; only the fields needed to address and update the counter are kept.
  logic [BHT_LOG_ROWS-1:0] fifo_row_q   [UPD_FIFO_DEPTH];
  logic [BHT_ROW_BITS-1:0] fifo_col_q   [UPD_FIFO_DEPTH];
  logic                    fifo_taken_q [UPD_FIFO_DEPTH];
  logic [PtrW-1:0]         wptr_q, rptr_q;
  logic [CntW-1:0]         fifo_cnt_q, fifo_cnt_d;

  logic                    push, pop;
  logic                    fifo_empty, fifo_full;
  logic [BHT_LOG_ROWS-1:0] upd_row, head_row;
  logic [BHT_ROW_BITS-1:0] upd_col, head_col;
  logic                    head_taken;
  logic [2:0]              rd_entry, new_entry;

  logic unused_pc;
  assign unused_pc = ^upd_pc_i;

  assign upd_row = upd_pc_i[BHT_OFFSET+BHT_ROW_BITS +: BHT_LOG_ROWS];
  assign upd_col = upd_pc_i[BHT_OFFSET +: BHT_ROW_BITS];

  assign head_row   = fifo_row_q[rptr_q];
  assign head_col   = fifo_col_q[rptr_q];
  assign head_taken = fifo_taken_q[rptr_q];

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == FullCnt);

  // Ready is based on the registered fill level only; a pop in the same cycle does not help.
  assign upd_ready_o = ~rst_i & ~flush_bp_i & (state_q != StSweep) & ~fifo_full;
  assign push        = upd_valid_i & upd_ready_o;
  assign pop         = ~rst_i & ~flush_bp_i & (state_q == StWr);
  assign fifo_cnt_d  = fifo_cnt_q + CntW'(push) - CntW'(pop);

  assign bht_busy_o = rst_i | (state_q == StSweep);

  // Counter update for the column selected by the FIFO head.
  always_comb begin
    rd_entry  = (head_col == '0) ? mem_rdata_i[2:0] : mem_rdata_i[5:3];
    new_entry = rd_entry;
    if (!rd_entry[2]) begin
      new_entry = {1'b1, head_taken ? 2'b10 : 2'b01};
    end else if (head_taken) begin
      new_entry = {1'b1, (rd_entry[1:0] == 2'b11) ? 2'b11 : rd_entry[1:0] + 2'b01};
    end else begin
      new_entry = {1'b1, (rd_entry[1:0] == 2'b00) ? 2'b00 : rd_entry[1:0] - 2'b01};
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 2'b00;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (rst_i) begin
      state_d     = StSweep;
      sweep_idx_d = '0;
    end else if (flush_bp_i) begin
      // Abandon whatever is in flight; nothing reaches the RAM this cycle.
      state_d     = StSweep;
      sweep_idx_d = '0;
    end else begin
      case (state_q)
        StSweep: begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_be_o    = 2'b11;
          mem_addr_o  = sweep_idx_q;
          sweep_idx_d = sweep_idx_q + BHT_LOG_ROWS'(1);
          if (sweep_idx_q == LastRow) begin
            state_d = StIdle;
          end
        end
        StIdle: begin
          if (!fifo_empty) begin
            state_d = StRd;
          end
        end
        StRd: begin
          mem_req_o  = 1'b1;
          mem_addr_o = head_row;
          state_d    = StWr;
        end
        StWr: begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_be_o    = (head_col == '0) ? 2'b01 : 2'b10;
          mem_addr_o  = head_row;
          mem_wdata_o = {new_entry, new_entry};
          // Head is popped this cycle: more work exists if another entry remains or arrives.
          state_d     = ((fifo_cnt_q != CntW'(1)) || push) ? StRd : StIdle;
        end
        default: begin
          state_d     = StSweep;
          sweep_idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StSweep;
      sweep_idx_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      if (flush_bp_i) begin
        wptr_q     <= '0;
        rptr_q     <= '0;
        fifo_cnt_q <= '0;
      end else begin
        if (push) begin
          wptr_q <= wptr_q + PtrW'(1);
        end
        if (pop) begin
          rptr_q <= rptr_q + PtrW'(1);
        end
        fifo_cnt_q <= fifo_cnt_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_row_q[wptr_q]   <= upd_row;
      fifo_col_q[wptr_q]   <= upd_col;
      fifo_taken_q[wptr_q] <= upd_taken_i;
    end
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl: sweep, counter updates, back-pressure, flush and reset.
module tb_bht_update_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        flush_bp_i;
  logic        upd_valid_i;
  logic        upd_ready_o;
  logic [63:0] upd_pc_i;
  logic        upd_taken_i;
  logic        bht_busy_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [5:0]  mem_addr_o;
  logic [1:0]  mem_be_o;
  logic [5:0]  mem_wdata_o;
  logic [5:0]  mem_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  bht_update_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_bp_i  (flush_bp_i),
    .upd_valid_i (upd_valid_i),
    .upd_ready_o (upd_ready_o),
    .upd_pc_i    (upd_pc_i),
    .upd_taken_i (upd_taken_i),
    .bht_busy_o  (bht_busy_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural BHT RAM: byte-enabled writes, registered read data.
  logic [5:0] ram [64];
  logic [5:0] rdata_q = '0;
  assign mem_rdata_i = rdata_q;

  always @(posedge clk_i) begin
    if (mem_req_o && mem_we_o) begin
      if (mem_be_o[0]) ram[mem_addr_o][2:0] <= mem_wdata_o[2:0];
      if (mem_be_o[1]) ram[mem_addr_o][5:3] <= mem_wdata_o[5:3];
    end
    if (mem_req_o && !mem_we_o) rdata_q <= ram[mem_addr_o];
  end

  logic [17:0] obs;
  assign obs = {bht_busy_o, upd_ready_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sweep_chk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check_eq(tag, obs, {1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 6'(i), 6'd0});
      step();
    end
  endtask

  task automatic idle_chk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check_eq(tag, {bht_busy_o, upd_ready_o, mem_req_o}, 3'b010);
      step();
    end
  endtask

  // One isolated update from an empty, idle controller.
  task automatic upd_one(input string tag, input logic [63:0] pc, input logic tk,
                         input logic [2:0] exp_v);
    logic [5:0] row;
    logic       col;
    row = pc[7:2];
    col = pc[1];
    upd_valid_i = 1'b1;
    upd_pc_i    = pc;
    upd_taken_i = tk;
    @(negedge clk_i);
    check_eq({tag, "_rdy"}, upd_ready_o, 1'b1);
    step();
    upd_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq({tag, "_idle"}, mem_req_o, 1'b0);
    step();
    @(negedge clk_i);
    check_eq({tag, "_rd"}, {mem_req_o, mem_we_o, mem_addr_o}, {2'b10, row});
    step();
    @(negedge clk_i);
    check_eq({tag, "_wr"}, {mem_req_o, mem_we_o, mem_be_o, mem_addr_o},
             {2'b11, col ? 2'b10 : 2'b01, row});
    check_eq({tag, "_ctr"}, col ? mem_wdata_o[5:3] : mem_wdata_o[2:0], exp_v);
    step();
    @(negedge clk_i);
    check_eq({tag, "_back"}, mem_req_o, 1'b0);
    step();
  endtask

  logic [63:0] b_pc  [5] = '{64'h100, 64'h102, 64'h10c, 64'h1fe, 64'h008};
  logic        b_tk  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [5:0]  b_row [5] = '{6'd0, 6'd0, 6'd3, 6'd63, 6'd2};
  logic        b_col [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [2:0]  b_ctr [5] = '{3'b110, 3'b101, 3'b110, 3'b101, 3'b110};
  logic        b_rdy [13] = '{1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1};
  logic [1:0]  b_rw  [13] = '{0, 0, 2, 3, 2, 3, 2, 3, 2, 3, 2, 3, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int e;
    logic acc;
    rst_i       = 1'b1;
    flush_bp_i  = 1'b0;
    upd_valid_i = 1'b0;
    upd_pc_i    = '0;
    upd_taken_i = 1'b0;

    // Reset values, then the initial clear sweep.
    @(negedge clk_i);
    check_eq("rst_out", obs, 18'h20000);
    step();
    @(negedge clk_i);
    check_eq("rst_out2", obs, 18'h20000);
    step();
    rst_i = 1'b0;
    sweep_chk("sweep0", 64);
    idle_chk("idle0", 3);

    // First touch of an entry, then saturation both ways on the neighbouring column.
    upd_one("pc84", 64'h84, 1'b1, 3'b110);
    upd_one("t1", 64'h86, 1'b1, 3'b110);
    upd_one("t2", 64'h86, 1'b1, 3'b111);
    upd_one("t3", 64'h86, 1'b1, 3'b111);
    upd_one("t4", 64'h86, 1'b1, 3'b111);
    upd_one("n1", 64'h86, 1'b0, 3'b110);
    upd_one("n2", 64'h86, 1'b0, 3'b101);
    upd_one("n3", 64'h86, 1'b0, 3'b100);

    // Back-to-back stream with valid held: FIFO fills, ready tracks pops.
    k = 0;
    for (int c = 0; c < 13; c++) begin
      upd_valid_i = (k < 5);
      if (k < 5) begin
        upd_pc_i    = b_pc[k];
        upd_taken_i = b_tk[k];
      end
      @(negedge clk_i);
      check_eq("burst_rdy", upd_ready_o, b_rdy[c]);
      check_eq("burst_rw", {mem_req_o, mem_we_o}, b_rw[c]);
      if (mem_req_o && c >= 2) begin
        e = (c - 2) / 2;
        check_eq("burst_addr", mem_addr_o, b_row[e]);
        if (mem_we_o) begin
          check_eq("burst_be", mem_be_o, b_col[e] ? 2'b10 : 2'b01);
          check_eq("burst_ctr", b_col[e] ? mem_wdata_o[5:3] : mem_wdata_o[2:0], b_ctr[e]);
        end
      end
      acc = upd_valid_i & upd_ready_o;
      step();
      if (acc) k++;
    end
    upd_valid_i = 1'b0;
    check_eq("burst_cnt", k, 5);
    idle_chk("idle1", 2);

    // Flush during the read of a pending update.
    upd_valid_i = 1'b1;
    upd_pc_i    = 64'h84;
    upd_taken_i = 1'b1;
    step();
    upd_valid_i = 1'b0;
    step();
    check_eq("pre_flush_rd", {mem_req_o, mem_we_o, mem_addr_o}, {2'b10, 6'h21});
    flush_bp_i = 1'b1;
    @(negedge clk_i);
    check_eq("flush_cyc", {bht_busy_o, upd_ready_o, mem_req_o}, 3'b000);
    step();
    flush_bp_i  = 1'b0;
    // Updates offered during the sweep must be refused.
    upd_valid_i = 1'b1;
    upd_pc_i    = 64'h200;
    sweep_chk("sweep_flush", 64);
    upd_valid_i = 1'b0;
    idle_chk("idle2", 3);

    // Reset in the middle of a sweep restarts it from row 0.
    flush_bp_i = 1'b1;
    @(negedge clk_i);
    check_eq("flush2", mem_req_o, 1'b0);
    step();
    flush_bp_i = 1'b0;
    sweep_chk("sweep_pre", 30);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_eq("mid_rst", obs, 18'h20000);
    step();
    @(negedge clk_i);
    check_eq("mid_rst2", obs, 18'h20000);
    step();
    rst_i = 1'b0;
    sweep_chk("sweep_rst", 64);
    idle_chk("idle3", 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
